// File: rtl/rvfi_imem_fetch_arbiter_if.sv
// ============================================================================
// Module      : rvfi_imem_fetch_arbiter_if
// Description : Requester, backing-port and symbolic-halfword bundle for the
//               instruction-fetch arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rvfi_imem_fetch_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*XLEN-1:0] req_addr;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [31:0]          rdata;
    logic                 rerr;

    logic                 mem_req;
    logic [XLEN-1:0]      mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;

    logic [XLEN-1:0]      imem_addr;
    logic [15:0]          imem_data;
    logic                 busy;

    // Environment side: requesters, backing memory and formal symbols.
    modport master (
        output req, req_addr, mem_gnt, mem_rvalid, mem_rdata, imem_addr, imem_data,
        input  gnt, rvalid, rdata, rerr, mem_req, mem_addr, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr, mem_gnt, mem_rvalid, mem_rdata, imem_addr, imem_data,
        output gnt, rvalid, rdata, rerr, mem_req, mem_addr, busy
    );
endinterface

`default_nettype wire

// File: rtl/rvfi_imem_fetch_arbiter.sv
// ============================================================================
// Module      : rvfi_imem_fetch_arbiter
// Description : Round-robin arbiter sharing one instruction-memory port among
//               NREQ fetch requesters, overlaying the symbolic halfword onto
//               returned words. Optional WAIT timeout:
//               RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_imem_fetch_arbiter #(
    parameter int XLEN    = 32,
    parameter int NREQ    = 2,
    parameter int MAX_LAT = 15
) (
    input  wire logic               clk,
    input  wire logic               reset,
    rvfi_imem_fetch_arbiter_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("rvfi_imem_fetch_arbiter: NREQ must be 1..8");
    end
    if (MAX_LAT < 1 || MAX_LAT > 255) begin : g_bad_max_lat
        $error("rvfi_imem_fetch_arbiter: MAX_LAT must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [XLEN-1:0]   addr;
    logic              mem_req_q;
    logic              busy_q;
    logic [NREQ-1:0]   rvalid_q;
    logic [31:0]       rdata_q;
    logic              rerr_q;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [XLEN-1:0]   req_addr_win;
    logic [XLEN-1:0]   addr_plus2;
    logic [31:0]       word;
    logic [NREQ-1:0]   owner_oh;
    logic [PTR_W-1:0]  ptr_next;

    // First asserted request scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        logic [PTR_W:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NREQ)) begin
                pos = pos - (PTR_W+1)'(NREQ);
            end
            if (!win_found && bus.req[pos[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        req_addr_win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                req_addr_win = bus.req_addr[k*XLEN +: XLEN];
            end
        end
    end

    // Address arithmetic wraps at 2^XLEN, so a fetch at the top halfword
    // still matches a symbolic address of zero in its upper half.
    assign addr_plus2 = addr + XLEN'(2);

    always_comb begin
        word = bus.mem_rdata;
        if (addr == bus.imem_addr) begin
            word[15:0] = bus.imem_data;
        end else if (addr_plus2 == bus.imem_addr) begin
            word[31:16] = bus.imem_data;
        end
    end

    assign owner_oh = NREQ'(1) << owner;
    assign ptr_next = (owner == PTR_W'(NREQ-1)) ? '0 : owner + PTR_W'(1);

`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            addr      <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner     <= win_idx;
                        addr      <= req_addr_win & {{(XLEN-1){1'b1}}, 1'b0};
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state     <= WAIT;
`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rvalid_q <= owner_oh;
                        rdata_q  <= word;
                        state    <= RESP;
                    end
`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
                    // The count reaches MAX_LAT on this cycle's increment.
                    else if (wait_cnt == 8'(MAX_LAT-1)) begin
                        rvalid_q <= owner_oh;
                        rerr_q   <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= ptr_next;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = (state == IDLE && win_found) ? (NREQ'(1) << win_idx) : '0;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = addr;
    assign bus.busy     = busy_q;
`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
    assign bus.rerr     = rerr_q;
`else
    assign bus.rerr     = 1'b0;
`endif

endmodule

`default_nettype wire
